// File: rtl/carry_chain_serial_adder.sv
// Slice-serial wide adder/subtractor: one WIDTH-bit slice per cycle, LSB first,
// through a ripple P/G carry chain whose carry-out is registered between slices.

module carry_chain_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  logic p, g;
  assign p    = a_i ^ b_i;
  assign g    = a_i & b_i;
  assign co_o = p ? c_i : g;
  assign s_o  = p ^ c_i;
endmodule

module carry_chain_serial_adder #(
  parameter int WIDTH  = 4,
  parameter int SLICES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  input  logic                    in_ci,
  input  logic                    in_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*SLICES-1:0] out_sum,
  output logic                    out_co,
  output logic                    out_ovf
);
  localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    carry_q, carry_d;
  logic                    sub_q, sub_d;
  logic [WIDTH*SLICES-1:0] sum_q, sum_d;
  logic                    co_q, co_d;
  logic                    ovf_q, ovf_d;

  logic                    accept, last, sub_eff, is_idle;
  logic [CW-1:0]           slice_idx;
  logic [WIDTH-1:0]        b_eff, s;
  logic [WIDTH:0]          c;

  assign is_idle   = (state_q == IDLE);
  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  // Mode and carry-in come from the ports only on the first slice.
  assign sub_eff   = is_idle ? in_sub : sub_q;
  assign b_eff     = in_b ^ {WIDTH{sub_eff}};
  assign c[0]      = is_idle ? (in_ci ^ in_sub) : carry_q;
  assign slice_idx = is_idle ? '0 : cnt_q;
  assign last      = is_idle ? (SLICES == 1) : (cnt_q == CW'(SLICES - 1));

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    carry_chain_bit u_bit (
      .a_i  (in_a[i]),
      .b_i  (b_eff[i]),
      .c_i  (c[i]),
      .s_o  (s[i]),
      .co_o (c[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if (is_idle) sub_d = in_sub;
          for (int k = 0; k < SLICES; k++)
            if (slice_idx == CW'(k)) sum_d[k*WIDTH +: WIDTH] = s;
          carry_d = c[WIDTH];
          if (last) begin
            state_d = DONE;
            cnt_d   = '0;
            co_d    = c[WIDTH];
            ovf_d   = c[WIDTH-1] ^ c[WIDTH];
          end else begin
            state_d = RUN;
            cnt_d   = slice_idx + CW'(1);
          end
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_sum = sum_q;
  assign out_co  = co_q;
  assign out_ovf = ovf_q;
endmodule

// File: tb/tb_carry_chain_serial_adder.sv
// Directed bench for carry_chain_serial_adder (WIDTH=4, SLICES=4).
module tb_carry_chain_serial_adder;
  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_a, in_b;
  logic        in_ci, in_sub;
  logic        out_valid, out_ready;
  logic [15:0] out_sum;
  logic        out_co, out_ovf;

  int errors = 0;
  int checks = 0;

  carry_chain_serial_adder #(.WIDTH(4), .SLICES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds four slices LSB first; optional 3-cycle gaps before slices 1 and 3,
  // and optional inversion of in_sub/in_ci on slices after the first.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic sub, input bit stall, input bit tog);
    for (int k = 0; k < 4; k++) begin
      if (stall && (k == 1 || k == 3)) begin
        in_valid = 1'b0;
        in_a = 4'hA; in_b = 4'h5;
        repeat (3) step();
        chk("stall_ready", {31'd0, in_ready}, 32'd1);
        chk("stall_valid", {31'd0, out_valid}, 32'd0);
      end
      in_valid = 1'b1;
      in_a     = a[4*k +: 4];
      in_b     = b[4*k +: 4];
      in_sub   = (tog && k > 0) ? ~sub : sub;
      in_ci    = (tog && k > 0) ? ~ci  : ci;
      if (k == 3) chk("pre_valid", {31'd0, out_valid}, 32'd0);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [15:0] sum, input logic co, input logic ovf);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"},   {16'd0, out_sum},   {16'd0, sum});
    chk({tag, "_co"},    {31'd0, out_co},    {31'd0, co});
    chk({tag, "_ovf"},   {31'd0, out_ovf},   {31'd0, ovf});
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_ci = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_sum",   {16'd0, out_sum}, 32'd0);
    chk("rst_co",    {31'd0, out_co}, 32'd0);
    chk("rst_ovf",   {31'd0, out_ovf}, 32'd0);

    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 0);
    chk_res("add1", 16'h2233, 1'b0, 1'b0);
    drain();

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0);
    chk_res("addwrap", 16'h0000, 1'b1, 1'b0);
    drain();

    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0);
    chk_res("addovf", 16'h8000, 1'b0, 1'b1);
    drain();

    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 0);
    chk_res("sub1", 16'hFFFE, 1'b0, 1'b0);
    drain();

    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 0);
    chk_res("subovf", 16'h7FFF, 1'b1, 1'b1);
    drain();

    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 0);
    chk_res("subbor", 16'hFFFD, 1'b0, 1'b0);
    drain();

    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1, 1);
    chk_res("stall", 16'h2233, 1'b0, 1'b0);
    drain();

    // Backpressure: hold out_ready low while offering a slice in DONE.
    out_ready = 1'b0;
    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 0);
    in_valid = 1'b1; in_a = 4'h1; in_b = 4'h1; in_sub = 1'b0; in_ci = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      chk_res("bp", 16'h2233, 1'b0, 1'b0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 0);
    chk_res("bp_next", 16'h0002, 1'b0, 1'b0);
    drain();

    // Reset mid-operation with the carry register set.
    in_valid = 1'b1; in_a = 4'hF; in_b = 4'hF; in_sub = 1'b0; in_ci = 1'b0;
    step(); step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 0);
    chk_res("after_rst", 16'h0002, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/carry_chain_serial_adder.md
Name: carry_chain_serial_adder

Overview:
- Multi-cycle wide adder/subtractor that consumes operands one WIDTH-bit slice per cycle, LSB slice first.
- Each slice goes through a per-bit propagate/generate/mux carry chain. The slice carry-out is registered and fed back as the next slice's carry-in.
- It is the receiving end of a chain's Co, so fabric-side wide arithmetic can run on narrow carry hardware.
- Completed results are presented on a valid/ready output port.

Parameters:
- WIDTH, 4, bits per slice (width of the combinational carry chain).
- SLICES, 4, slices per operation; result width = WIDTH*SLICES.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  slice operands present.
- in_ready  output  1  block accepts a slice this cycle.
- in_a  input  WIDTH  operand A slice.
- in_b  input  WIDTH  operand B slice.
- in_ci  input  1  carry-in (add) or borrow-in (sub); sampled on the first slice only.
- in_sub  input  1  1 = A-B; sampled on the first slice only.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer takes the result.
- out_sum  output  WIDTH*SLICES  assembled result.
- out_co  output  1  raw carry-out of the MSB bit of the final slice.
- out_ovf  output  1  signed overflow.

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE; slice counter = 0; carry register = 0; sub latch = 0.
  - out_sum = 0, out_co = 0, out_ovf = 0, out_valid = 0, in_ready = 1.
  - Reset asserted mid-operation discards the partial result; no output is produced.
- States: IDLE, RUN, DONE. in_ready = 1 in IDLE and RUN, 0 in DONE. out_valid = 1 only in DONE.
- Slice acceptance: a slice is accepted when in_valid && in_ready.
- Per-bit chain for the effective operand b' = in_b XOR {WIDTH{sub}}:
  - P = a ^ b', G = a & b'.
  - Bit carry-out = P ? Ci : G.
  - Sum bit = P ^ Ci.
- Carry into slice 0 = in_ci XOR in_sub. In sub mode, in_ci = 0 gives A-B and in_ci = 1 gives A-B-1.
- IDLE, slice accepted:
  - Latch in_sub.
  - Write the slice sum to out_sum bits [WIDTH-1:0].
  - Store the slice carry-out; counter = 1.
  - Go to RUN, or directly to DONE if SLICES == 1.
- RUN, slice accepted:
  - Carry-in = carry register; b' uses the latched sub, and in_sub/in_ci are ignored.
  - Write the sum to slice position counter; store the carry-out; increment the counter.
  - On the final slice (counter == SLICES-1): go to DONE; counter = 0; register out_co = final carry-out and out_ovf = carry into MSB bit XOR carry out of MSB bit.
- RUN, in_valid low: stall. Carry, counter and partial sum are held indefinitely.
- DONE:
  - out_sum/out_co/out_ovf are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE next cycle; out_valid drops.
  - in_valid is ignored in DONE, including the cycle out_ready is high, because in_ready = 0. The next slice is accepted at the earliest one cycle after the handshake.
- Latency: out_valid rises the cycle after the final slice is accepted. Minimum throughput is one operation per SLICES+1 cycles.
- Retention: out_sum keeps the last result after leaving DONE until overwritten slice by slice. Outputs are valid only while out_valid = 1.
- Modular arithmetic: the sum wraps mod 2^(WIDTH*SLICES). In sub mode out_co = 1 means no borrow.

Test Plan (WIDTH=4, SLICES=4, 16-bit result):
- Add 0x1234+0x0FFF, ci=0, slices back-to-back, out_ready=1 -> out_valid rises 1 cycle after 4th slice; sum=0x2233, co=0, ovf=0.
- Add 0xFFFF+0x0001 -> sum=0x0000, co=1, ovf=0. Then 0x7FFF+0x0001 -> sum=0x8000, co=0, ovf=1.
- Sub 0x0005-0x0007, ci=0 -> sum=0xFFFE, co=0, ovf=0. Sub 0x8000-0x0001 -> sum=0x7FFF, co=1, ovf=1.
- Stall: in_valid low 3 cycles between slices 1 and 2 and between slices 3 and 4, and in_sub toggled on later slices -> result identical to the unstalled case (0x2233); mode stays as latched on the first slice.
- Backpressure: out_ready low 5 cycles in DONE with in_valid high -> in_ready=0, outputs stable. On out_ready=1, IDLE next cycle; the next slice is accepted the following cycle.
- Reset after slice 2, then a full add 0x0001+0x0001 -> no spurious out_valid; result 0x0002, co=0 (no stale carry).
